// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the keypad matrix scanner.
//   scan_state_e : scan FSM states (DRIVE, SAMPLE, EMIT)
//   PRESS_BIT / ROW_LSB / COL_LSB : field positions inside an 8-bit event code
//   clog2        : ceiling log2 for sizing counters and pointers
package keypad_pkg;

  typedef enum logic [1:0] {
    DRIVE  = 2'd0,
    SAMPLE = 2'd1,
    EMIT   = 2'd2
  } scan_state_e;

  localparam int PRESS_BIT = 7;
  localparam int ROW_LSB   = 3;
  localparam int COL_LSB   = 0;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        res = i + 1;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/keypad_evt_fifo.sv
// keypad_evt_fifo: 8-bit synchronous event FIFO for the keypad scanner.
//   HCLK, HRESET : clock and asynchronous active-high reset
//   push, push_data : write request and data; ignored while full
//   pop          : read request; ignored while empty
//   full, empty  : status; fullness is judged on the count before any pop,
//                  so a pop in the same cycle never admits a push into a full FIFO
//   head         : entry at the read pointer
module keypad_evt_fifo
  import keypad_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [DEPTH-1:0][7:0] mem_r;
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [AW:0]           count_r;
  logic [AW:0]           count_nxt_s;
  logic                  empty_r;
  logic                  do_push_s;
  logic                  do_pop_s;

  assign full  = (count_r == FULL_CNT);
  assign empty = empty_r;
  assign head  = mem_r[rd_ptr_r];

  // Qualify requests against the current occupancy and derive the next count.
  always_comb begin
    do_push_s   = push & ~full;
    do_pop_s    = pop & ~empty_r;
    count_nxt_s = count_r;
    case ({do_push_s, do_pop_s})
      2'b10:   count_nxt_s = count_r + {{AW{1'b0}}, 1'b1};
      2'b01:   count_nxt_s = count_r - {{AW{1'b0}}, 1'b1};
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage, pointers and occupancy; empty is registered so the head flag is a flop.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      mem_r    <= {(DEPTH*8){1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      empty_r  <= 1'b1;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      count_r <= count_nxt_s;
      empty_r <= (count_nxt_s == {(AW+1){1'b0}});
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: scans a ROWS x COLS key matrix, debounces every key
// across scan frames and queues press/release events for the CPU.
//   HCLK, HRESET : clock and asynchronous active-high reset
//   col          : raw column returns (asynchronous, active-high)
//   row_drive    : one-hot row drive, zero while keys are evaluated
//   evt_valid / evt_ready / evt_code : event FIFO read port
//                  code = {press, 1'b0, row[2:0], col[2:0]}
//   key_irq      : level interrupt, high while the FIFO holds events
//   overflow     : sticky, set when an event is dropped; ovf_clr clears it
// Build option: define KEYPAD_GHOST_REJECT_EN to discard whole frames in
// which more than two keys read as pressed (possible ghosting).
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SETTLE_CYC     = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic            HCLK,
  input  logic            HRESET,
  input  logic [COLS-1:0] col,
  output logic [ROWS-1:0] row_drive,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [7:0]      evt_code,
  output logic            key_irq,
  output logic            overflow,
  input  logic            ovf_clr
);

  localparam int RW = (ROWS > 1) ? clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? clog2(COLS) : 1;
  localparam int SW = clog2(SETTLE_CYC + 1);

  logic [COLS-1:0]                 col_meta_r;
  logic [COLS-1:0]                 col_sync_r;
  scan_state_e                     state_r;
  scan_state_e                     state_nxt_s;
  logic [RW-1:0]                   row_r;
  logic [RW-1:0]                   row_nxt_s;
  logic [SW-1:0]                   settle_r;
  logic [SW-1:0]                   settle_nxt_s;
  logic [RW-1:0]                   key_row_r;
  logic [RW-1:0]                   key_row_nxt_s;
  logic [CW-1:0]                   key_col_r;
  logic [CW-1:0]                   key_col_nxt_s;
  logic [ROWS-1:0]                 row_drive_r;
  logic [ROWS-1:0]                 row_drive_nxt_s;
  logic [ROWS-1:0][COLS-1:0]       snap_r;
  logic [ROWS-1:0][COLS-1:0]       deb_r;
  logic [ROWS-1:0][COLS-1:0][3:0]  cnt_r;
  logic                            ghost_s;
  logic                            snap_bit_s;
  logic                            deb_bit_s;
  logic [3:0]                      cnt_cur_s;
  logic                            differs_s;
  logic                            push_s;
  logic [7:0]                      push_code_s;
  logic                            fifo_full_s;
  logic                            fifo_empty_s;
  logic                            overflow_r;

  // Two-flop synchronizer for the asynchronous column returns.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      col_meta_r <= {COLS{1'b0}};
      col_sync_r <= {COLS{1'b0}};
    end else begin
      col_meta_r <= col;
      col_sync_r <= col_meta_r;
    end
  end

`ifdef KEYPAD_GHOST_REJECT_EN
  logic [ROWS-1:0][COLS-1:0] frame_s;
  logic [6:0]                pressed_s;

  // Count pressed keys in the snapshot as it will stand once the last row is captured.
  always_comb begin
    frame_s         = snap_r;
    frame_s[ROWS-1] = col_sync_r;
    pressed_s       = 7'd0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        pressed_s = pressed_s + {6'd0, frame_s[r][c]};
      end
    end
  end

  assign ghost_s = (pressed_s > 7'd2);
`else
  assign ghost_s = 1'b0;
`endif

  // Scan FSM next state. Leaving reset the settle count starts at 0 so the first
  // row gets a full SETTLE_CYC driven cycles behind the registered row_drive;
  // later rows enter DRIVE with the count preloaded to 1.
  always_comb begin
    state_nxt_s   = state_r;
    row_nxt_s     = row_r;
    settle_nxt_s  = settle_r;
    key_row_nxt_s = key_row_r;
    key_col_nxt_s = key_col_r;
    case (state_r)
      DRIVE: begin
        if (settle_r == SW'(SETTLE_CYC)) begin
          state_nxt_s = SAMPLE;
        end else begin
          settle_nxt_s = settle_r + SW'(1);
        end
      end
      SAMPLE: begin
        settle_nxt_s = SW'(1);
        if (row_r == RW'(ROWS - 1)) begin
          row_nxt_s     = {RW{1'b0}};
          key_row_nxt_s = {RW{1'b0}};
          key_col_nxt_s = {CW{1'b0}};
          if (ghost_s) begin
            state_nxt_s = DRIVE;
          end else begin
            state_nxt_s = EMIT;
          end
        end else begin
          row_nxt_s   = row_r + RW'(1);
          state_nxt_s = DRIVE;
        end
      end
      EMIT: begin
        if (key_col_r == CW'(COLS - 1)) begin
          key_col_nxt_s = {CW{1'b0}};
          if (key_row_r == RW'(ROWS - 1)) begin
            key_row_nxt_s = {RW{1'b0}};
            state_nxt_s   = DRIVE;
          end else begin
            key_row_nxt_s = key_row_r + RW'(1);
          end
        end else begin
          key_col_nxt_s = key_col_r + CW'(1);
        end
      end
      default: begin
        state_nxt_s   = DRIVE;
        row_nxt_s     = {RW{1'b0}};
        settle_nxt_s  = {SW{1'b0}};
        key_row_nxt_s = {RW{1'b0}};
        key_col_nxt_s = {CW{1'b0}};
      end
    endcase
    if (state_nxt_s == EMIT) begin
      row_drive_nxt_s = {ROWS{1'b0}};
    end else begin
      row_drive_nxt_s = ROWS'(1'b1) << row_nxt_s;
    end
  end

  // Scan FSM state, counters and registered row drive.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_r     <= DRIVE;
      row_r       <= {RW{1'b0}};
      settle_r    <= {SW{1'b0}};
      key_row_r   <= {RW{1'b0}};
      key_col_r   <= {CW{1'b0}};
      row_drive_r <= {ROWS{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      row_r       <= row_nxt_s;
      settle_r    <= settle_nxt_s;
      key_row_r   <= key_row_nxt_s;
      key_col_r   <= key_col_nxt_s;
      row_drive_r <= row_drive_nxt_s;
    end
  end

  // Debounce decision for the key currently walked in EMIT.
  always_comb begin
    snap_bit_s  = snap_r[key_row_r][key_col_r];
    deb_bit_s   = deb_r[key_row_r][key_col_r];
    cnt_cur_s   = cnt_r[key_row_r][key_col_r];
    differs_s   = (snap_bit_s != deb_bit_s);
    push_s      = (state_r == EMIT) && differs_s && (cnt_cur_s == 4'(DEBOUNCE_SCANS - 1));
    push_code_s = 8'd0;
    push_code_s[PRESS_BIT]     = snap_bit_s;
    push_code_s[ROW_LSB +: 3]  = 3'(key_row_r);
    push_code_s[COL_LSB +: 3]  = 3'(key_col_r);
  end

  // Snapshot capture and per-key debounced state / disagreement counters.
  // The state flips on the final disagreeing frame even if the FIFO drops the event.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      snap_r <= {(ROWS*COLS){1'b0}};
      deb_r  <= {(ROWS*COLS){1'b0}};
      cnt_r  <= {(ROWS*COLS*4){1'b0}};
    end else begin
      if (state_r == SAMPLE) begin
        snap_r[row_r] <= col_sync_r;
      end
      if (state_r == EMIT) begin
        if (push_s) begin
          deb_r[key_row_r][key_col_r] <= ~deb_bit_s;
          cnt_r[key_row_r][key_col_r] <= 4'd0;
        end else if (differs_s) begin
          cnt_r[key_row_r][key_col_r] <= cnt_cur_s + 4'd1;
        end else begin
          cnt_r[key_row_r][key_col_r] <= 4'd0;
        end
      end
    end
  end

  // Sticky overflow; a drop in the same cycle as ovf_clr keeps it set.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      overflow_r <= 1'b0;
    end else if (push_s && fifo_full_s) begin
      overflow_r <= 1'b1;
    end else if (ovf_clr) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  keypad_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_evt_fifo (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .push      (push_s),
    .push_data (push_code_s),
    .pop       (evt_ready),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .head      (evt_code)
  );

  assign row_drive = row_drive_r;
  assign evt_valid = ~fifo_empty_s;
  assign key_irq   = ~fifo_empty_s;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
module tb_keypad_matrix_scanner;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int SETTLE = 4;
  localparam int DEB    = 2;
  localparam int DEPTH  = 4;
  localparam int FRAME  = ROWS * (SETTLE + 1) + ROWS * COLS;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [3:0]  col;
  logic [3:0]  row_drive;
  logic        evt_valid;
  logic        evt_ready;
  logic [7:0]  evt_code;
  logic        key_irq;
  logic        overflow;
  logic        ovf_clr;
  logic [15:0] keys;

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  exp_q[$];

  always #5 HCLK = ~HCLK;

  // Key matrix model: a pressed key connects its row drive to its column.
  always_comb begin
    col = 4'd0;
    for (int r = 0; r < ROWS; r++) begin
      if (row_drive[r]) col = col | keys[r*COLS +: COLS];
    end
  end

  keypad_matrix_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SETTLE_CYC(SETTLE),
    .DEBOUNCE_SCANS(DEB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .col(col), .row_drive(row_drive),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .key_irq(key_irq), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  function automatic logic [15:0] kbit(input int r, input int c);
    logic [15:0] v;
    v = 16'd0;
    v[r*COLS + c] = 1'b1;
    return v;
  endfunction

  function automatic logic [7:0] code(input logic press, input int r, input int c);
    logic [7:0] v;
    v      = 8'd0;
    v[7]   = press;
    v[5:3] = 3'(r);
    v[2:0] = 3'(c);
    return v;
  endfunction

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [15:0] k, input int nframes);
    keys = k;
    repeat (nframes * FRAME) tick();
  endtask

  task automatic sync_frame();
    logic [3:0] prev;
    int n;
    prev = row_drive;
    tick();
    n = 1;
    while (!(row_drive === 4'b0001 && prev !== 4'b0001) && n < 2 * FRAME) begin
      prev = row_drive;
      tick();
      n++;
    end
    chk("frame_sync", 32'(row_drive), 32'd1);
  endtask

  task automatic drain(input string tag);
    int n;
    evt_ready = 1'b0;
    while (exp_q.size() > 0) begin
      n = 0;
      while (evt_valid !== 1'b1 && n < 3 * FRAME) begin
        tick();
        n++;
      end
      chk({tag, "_valid"}, 32'(evt_valid), 32'd1);
      if (evt_valid !== 1'b1) begin
        exp_q.delete();
        break;
      end
      chk({tag, "_code"}, 32'(evt_code), 32'(exp_q.pop_front()));
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
    end
    chk({tag, "_empty"}, 32'(evt_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_rd;
    int j;
    HRESET = 1'b1; keys = 16'd0; evt_ready = 1'b0; ovf_clr = 1'b0;
    repeat (3) tick();

    // 1. reset values and the bare scan pattern
    chk("rst_row_drive", 32'(row_drive), 32'd0);
    chk("rst_evt_valid", 32'(evt_valid), 32'd0);
    chk("rst_evt_code",  32'(evt_code),  32'd0);
    chk("rst_key_irq",   32'(key_irq),   32'd0);
    chk("rst_overflow",  32'(overflow),  32'd0);
    HRESET = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      j = i % FRAME;
      if (j < ROWS * (SETTLE + 1)) exp_rd = 4'b0001 << (j / (SETTLE + 1));
      else exp_rd = 4'b0000;
      chk("t1_row_drive", 32'(row_drive), 32'(exp_rd));
    end
    chk("t1_evt_valid", 32'(evt_valid), 32'd0);

    // 2. single press and release of r1c2
    sync_frame();
    exp_q.push_back(code(1'b1, 1, 2));
    hold(kbit(1, 2), 2);
    chk("t2_valid", 32'(evt_valid), 32'd1);
    chk("t2_irq",   32'(key_irq),   32'd1);
    drain("t2_press");
    chk("t2_irq_clear", 32'(key_irq), 32'd0);
    sync_frame();
    exp_q.push_back(code(1'b0, 1, 2));
    hold(16'd0, 2);
    drain("t2_release");

    // 3. bounce shorter than the debounce window
    sync_frame();
    for (int b = 0; b < 4; b++) begin
      hold(kbit(1, 2), 1);
      hold(16'd0, 1);
    end
    hold(16'd0, 1);
    chk("t3_no_event", 32'(evt_valid), 32'd0);
    chk("t3_overflow", 32'(overflow),  32'd0);

    // 4. overflow: five events into a four-entry FIFO
    sync_frame();
    exp_q.push_back(code(1'b1, 0, 0));
    exp_q.push_back(code(1'b1, 2, 3));
    hold(kbit(0, 0) | kbit(2, 3), 2);
    exp_q.push_back(code(1'b0, 0, 0));
    exp_q.push_back(code(1'b0, 2, 3));
    hold(16'd0, 2);
    hold(kbit(3, 1), 2);
    chk("t4_overflow", 32'(overflow),  32'd1);
    chk("t4_valid",    32'(evt_valid), 32'd1);
    drain("t4_drain");
    chk("t4_ovf_sticky", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t4_ovf_clr", 32'(overflow), 32'd0);
    sync_frame();
    exp_q.push_back(code(1'b0, 3, 1));
    hold(16'd0, 2);
    drain("t4_release");

    // 5. reset in the SAMPLE cycle of row 2 with two events queued
    sync_frame();
    hold(kbit(0, 0) | kbit(1, 1), 2);
    chk("t5_queued", 32'(evt_valid), 32'd1);
    j = 0;
    while (row_drive !== 4'b0100 && j < 2 * FRAME) begin
      tick();
      j++;
    end
    chk("t5_row2", 32'(row_drive), 32'h4);
    repeat (SETTLE) tick();
    chk("t5_sample_row2", 32'(row_drive), 32'h4);
    HRESET = 1'b1;
    #1;
    chk("t5_async_row_drive", 32'(row_drive), 32'd0);
    chk("t5_async_evt_valid", 32'(evt_valid), 32'd0);
    chk("t5_async_evt_code",  32'(evt_code),  32'd0);
    chk("t5_async_key_irq",   32'(key_irq),   32'd0);
    chk("t5_async_overflow",  32'(overflow),  32'd0);
    keys = 16'd0;
    tick();
    chk("t5_held_row_drive", 32'(row_drive), 32'd0);
    chk("t5_held_evt_valid", 32'(evt_valid), 32'd0);
    HRESET = 1'b0;
    tick();
    chk("t5_restart_row0", 32'(row_drive), 32'h1);
    repeat (SETTLE) tick();
    chk("t5_row0_last", 32'(row_drive), 32'h1);
    tick();
    chk("t5_row1_first", 32'(row_drive), 32'h2);
    sync_frame();
    exp_q.push_back(code(1'b1, 0, 0));
    exp_q.push_back(code(1'b1, 1, 1));
    hold(kbit(0, 0) | kbit(1, 1), 2);
    drain("t5_press");
    sync_frame();
    exp_q.push_back(code(1'b0, 0, 0));
    exp_q.push_back(code(1'b0, 1, 1));
    hold(16'd0, 2);
    drain("t5_release");

    // 6. three keys held at once (possible ghosting)
    sync_frame();
`ifndef KEYPAD_GHOST_REJECT_EN
    exp_q.push_back(code(1'b1, 0, 0));
    exp_q.push_back(code(1'b1, 0, 1));
    exp_q.push_back(code(1'b1, 1, 0));
`endif
    hold(kbit(0, 0) | kbit(0, 1) | kbit(1, 0), 4);
    drain("t6_press");
    sync_frame();
`ifndef KEYPAD_GHOST_REJECT_EN
    exp_q.push_back(code(1'b0, 0, 0));
    exp_q.push_back(code(1'b0, 0, 1));
    exp_q.push_back(code(1'b0, 1, 0));
`endif
    hold(16'd0, 4);
    drain("t6_release");
    chk("t6_overflow", 32'(overflow), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
